// File: rtl/dat_mmu_tasked_pkg.sv
// Shared constants and helpers for the tasked DAT MMU: register map, bit positions,
// register-select decode and the on-board bank test.
package dat_mmu_pkg;

    localparam logic [7:0] REG_INIT0      = 8'h90;
    localparam logic [7:0] REG_ACTIVE     = 8'h91;
    localparam logic [7:0] REG_ACCESS     = 8'h92;
    localparam logic [7:0] REG_SYSTEM     = 8'h93;
    localparam logic [7:0] REG_SAVED      = 8'h94;
    localparam logic [7:0] REG_STATUS     = 8'h95;
    localparam logic [7:0] REG_FAULT_ADDR = 8'h96;
    localparam logic [7:0] REG_TBL_LO     = 8'hA0;
    localparam logic [7:0] REG_TBL_HI     = 8'hA8;

    localparam int unsigned INIT0_MMU_EN  = 6;
    localparam int unsigned INIT0_CRM_EN  = 3;
    localparam int unsigned INIT0_AUTO_EN = 0;

    localparam int unsigned STAT_FAULT = 7;
    localparam int unsigned STAT_OVF   = 6;
    localparam int unsigned STAT_UNF   = 5;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_INIT0,
        SEL_ACTIVE,
        SEL_ACCESS,
        SEL_SYSTEM,
        SEL_SAVED,
        SEL_STATUS,
        SEL_FAULT_ADDR,
        SEL_TBL_LO,
        SEL_TBL_HI
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(input logic [7:0] off);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (off[7:3] == REG_TBL_LO[7:3]) sel = SEL_TBL_LO;
        else if (off[7:3] == REG_TBL_HI[7:3]) sel = SEL_TBL_HI;
        else begin
            case (off)
                REG_INIT0:      sel = SEL_INIT0;
                REG_ACTIVE:     sel = SEL_ACTIVE;
                REG_ACCESS:     sel = SEL_ACCESS;
                REG_SYSTEM:     sel = SEL_SYSTEM;
                REG_SAVED:      sel = SEL_SAVED;
                REG_STATUS:     sel = SEL_STATUS;
                REG_FAULT_ADDR: sel = SEL_FAULT_ADDR;
                default:        sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Banks 0-7 belong to the motherboard; anything above is on-board RAM.
    function automatic logic bank_is_internal(input logic [31:0] bank);
        return bank >= 32'd8;
    endfunction

endpackage

// File: rtl/dat_mmu_tasked_if.sv
// CPU-side and memory-side bus of the tasked DAT MMU.
interface dat_mmu_tasked_if #(
    parameter int unsigned BANK_BITS = 8
);
    logic [15:0]          address_cpu;
    logic                 r_w_cpu;
    logic                 bs;
    logic                 ba;
    logic [7:0]           data_in;
    logic [7:0]           data_out;
    logic                 data_oe;
    logic [BANK_BITS+12:0] address_mem;
    logic                 ce_mem;
    logic                 we_mem;
    logic                 r_w_brd;
    logic                 fault;

    modport master (
        output address_cpu, r_w_cpu, bs, ba, data_in,
        input  data_out, data_oe, address_mem, ce_mem, we_mem, r_w_brd, fault
    );

    modport slave (
        input  address_cpu, r_w_cpu, bs, ba, data_in,
        output data_out, data_oe, address_mem, ce_mem, we_mem, r_w_brd, fault
    );
endinterface

// File: rtl/dat_mmu_tasked_stack.sv
// LIFO of interrupted task numbers; top reads zero when empty.
module task_stack #(
    parameter int unsigned TASK_BITS   = 5,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [TASK_BITS-1:0] din,
    output logic [TASK_BITS-1:0] top,
    output logic [3:0]           depth,
    output logic                 full,
    output logic                 empty
);
    localparam int unsigned PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [TASK_BITS-1:0] mem [STACK_DEPTH];
    logic [3:0]           depth_q;
    logic [3:0]           depth_m1;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        top_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign depth_m1 = depth_q - 4'd1;
    assign wr_ptr   = depth_q[PW-1:0];
    assign top_ptr  = depth_m1[PW-1:0];
    assign full     = (depth_q == 4'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty & ~push;
    assign top      = empty ? '0 : mem[top_ptr];
    assign depth    = depth_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) depth_q <= '0;
        else if (do_push) depth_q <= depth_q + 4'd1;
        else if (do_pop) depth_q <= depth_m1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/dat_mmu_tasked.sv
// DAT MMU with internal task table, hardware task stack on vector fetch and
// per-page write protect with a sticky fault latch.
module dat_mmu_tasked
    import dat_mmu_pkg::*;
#(
    parameter int unsigned BANK_BITS   = 8,
    parameter int unsigned TASK_BITS   = 5,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic              e,
    input logic              reset,
    dat_mmu_tasked_if.slave  bus
);
    localparam int unsigned HI_W  = BANK_BITS - 7;
    localparam int unsigned IDX_W = TASK_BITS + 3;
    localparam int unsigned TBL_N = 1 << IDX_W;

    logic                 mmu_en_q, crm_en_q, auto_en_q;
    logic [TASK_BITS-1:0] active_q, access_q, system_q;
    logic                 fault_q, ovf_q, unf_q;
    logic [7:0]           fault_addr_q;
    logic                 bs_q;

    logic [7:0]      tbl_lo [TBL_N];
    logic [HI_W-1:0] tbl_hi [TBL_N];

    logic [TASK_BITS-1:0] stk_top;
    logic [3:0]           stk_depth;
    logic                 stk_full, stk_empty;

    logic [2:0]           page;
    logic                 is_ff, is_vec_area, crm_hit, mapped;
    logic [IDX_W-1:0]     act_idx, acc_idx;
    logic [BANK_BITS:0]   act_entry;
    logic [BANK_BITS-1:0] bank;
    logic                 wp;
    logic                 ce;
    reg_sel_e             sel;
    logic                 reg_hit, reg_we;
    logic                 vec_switch, push, pop_req;
    logic                 fault_set, ovf_set, unf_set;
    logic [7:0]           w1c;
    logic [7:0]           rdata;

    function automatic logic [HI_W-1:0] byte_to_hi(input logic [7:0] d);
        logic [HI_W-1:0] h;
        h = '0;
        h[HI_W-1] = d[7];
        for (int unsigned i = 0; i + 1 < HI_W; i++) h[i] = d[i];
        return h;
    endfunction

    function automatic logic [7:0] hi_to_byte(input logic [HI_W-1:0] h);
        logic [7:0] b;
        b = '0;
        b[7] = h[HI_W-1];
        for (int unsigned i = 0; i + 1 < HI_W; i++) b[i] = h[i];
        return b;
    endfunction

    assign page        = bus.address_cpu[15:13];
    assign is_ff       = (bus.address_cpu[15:8] == 8'hFF);
    assign is_vec_area = (bus.address_cpu[15:4] == 12'hFFF);
    assign crm_hit     = crm_en_q & ((bus.address_cpu[15:8] == 8'hFE) | is_vec_area);
    // FFF0-FFFF stay mapped so the vectors come through the table; FF00-FFEF never do.
    assign mapped      = mmu_en_q & (~is_ff | is_vec_area);
    assign act_idx     = {active_q, page};
    assign acc_idx     = {access_q, bus.address_cpu[2:0]};
    assign act_entry   = {tbl_hi[act_idx], tbl_lo[act_idx]};

    always_comb begin
        bank = '0;
        wp   = 1'b0;
        if (!mmu_en_q) begin
            bank = BANK_BITS'(page);
        end else if (crm_hit) begin
            bank = '1;
        end else begin
            bank = act_entry[BANK_BITS-1:0];
            wp   = act_entry[BANK_BITS] & mapped;
        end
    end

    assign ce              = mapped & bank_is_internal(32'(bank));
    assign bus.address_mem = {bank, bus.address_cpu[12:0]};
    assign bus.ce_mem      = ce;
    assign bus.we_mem      = e & ~bus.r_w_cpu & ce & ~wp;
    assign bus.r_w_brd     = bus.r_w_cpu | ce;
    assign bus.fault       = fault_q;

    assign sel     = is_ff ? reg_decode(bus.address_cpu[7:0]) : SEL_NONE;
    assign reg_hit = (sel != SEL_NONE);

    // A vector-fetch switch owns the edge; any coincident register write is dropped.
    assign vec_switch = bus.bs & ~bus.ba & ~bs_q & auto_en_q;
    assign reg_we     = reg_hit & ~bus.r_w_cpu & ~vec_switch;
    assign push       = vec_switch & ~stk_full;
    assign pop_req    = reg_we & (sel == SEL_SAVED);
    assign fault_set  = wp & ~bus.r_w_cpu;
    assign ovf_set    = vec_switch & stk_full;
    assign unf_set    = pop_req & stk_empty;
    assign w1c        = (reg_we && sel == SEL_STATUS) ? bus.data_in : '0;

    task_stack #(
        .TASK_BITS  (TASK_BITS),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk  (e),
        .rst  (reset),
        .push (push),
        .pop  (pop_req),
        .din  (active_q),
        .top  (stk_top),
        .depth(stk_depth),
        .full (stk_full),
        .empty(stk_empty)
    );

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_INIT0: begin
                rdata[INIT0_MMU_EN]  = mmu_en_q;
                rdata[INIT0_CRM_EN]  = crm_en_q;
                rdata[INIT0_AUTO_EN] = auto_en_q;
            end
            SEL_ACTIVE:     rdata = 8'(active_q);
            SEL_ACCESS:     rdata = 8'(access_q);
            SEL_SYSTEM:     rdata = 8'(system_q);
            SEL_SAVED:      rdata = 8'(stk_top);
            SEL_STATUS: begin
                rdata[STAT_FAULT] = fault_q;
                rdata[STAT_OVF]   = ovf_q;
                rdata[STAT_UNF]   = unf_q;
                rdata[3:0]        = stk_depth;
            end
            SEL_FAULT_ADDR: rdata = fault_addr_q;
            SEL_TBL_LO:     rdata = tbl_lo[acc_idx];
            SEL_TBL_HI:     rdata = hi_to_byte(tbl_hi[acc_idx]);
            default:        rdata = '0;
        endcase
    end

    assign bus.data_out = rdata;
    assign bus.data_oe  = reg_hit & bus.r_w_cpu;

    always_ff @(posedge e or posedge reset) begin
        if (reset) begin
            mmu_en_q     <= 1'b0;
            crm_en_q     <= 1'b0;
            auto_en_q    <= 1'b0;
            active_q     <= '0;
            access_q     <= '0;
            system_q     <= '0;
            fault_q      <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            fault_addr_q <= '0;
            bs_q         <= 1'b0;
        end else begin
            bs_q <= bus.bs;
            if (vec_switch) active_q <= system_q;
            else if (pop_req && !stk_empty) active_q <= stk_top;
            else if (reg_we && sel == SEL_ACTIVE) active_q <= bus.data_in[TASK_BITS-1:0];
            if (reg_we && sel == SEL_INIT0) begin
                mmu_en_q  <= bus.data_in[INIT0_MMU_EN];
                crm_en_q  <= bus.data_in[INIT0_CRM_EN];
                auto_en_q <= bus.data_in[INIT0_AUTO_EN];
            end
            if (reg_we && sel == SEL_ACCESS) access_q <= bus.data_in[TASK_BITS-1:0];
            if (reg_we && sel == SEL_SYSTEM) system_q <= bus.data_in[TASK_BITS-1:0];
            fault_q <= fault_set | (fault_q & ~w1c[STAT_FAULT]);
            ovf_q   <= ovf_set | (ovf_q & ~w1c[STAT_OVF]);
            unf_q   <= unf_set | (unf_q & ~w1c[STAT_UNF]);
            if (fault_set && !fault_q) fault_addr_q <= bus.address_cpu[15:8];
        end
    end

    always_ff @(posedge e) begin
        if (reg_we && sel == SEL_TBL_LO) tbl_lo[acc_idx] <= bus.data_in;
        if (reg_we && sel == SEL_TBL_HI) tbl_hi[acc_idx] <= byte_to_hi(bus.data_in);
    end
endmodule
